mac_frame_checker: RTL and testbench

- Receive-side counterpart of the MAC frame generator: consumes the 64-bit word stream (preamble+SFD, header, payload, padding) framed by a valid strobe.
- Checks and strips the preamble, then latches destination, source and EtherType.
- Realigns payload bytes onto 64-bit word boundaries with byte-keep and emits them downstream.
- Reports per-frame status (byte count, error flags) with a done pulse. Sits in the verification loopback between the generator and the scoreboard.

---
 rtl/mac_frame_checker.sv | 178 +++++++++++++++++
 tb/tb_mac_frame_checker.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_frame_checker.sv
// Receive-side MAC frame checker: validates preamble/SFD, latches the header,
// realigns payload onto 64-bit boundaries and reports per-frame status.
module mac_frame_checker #(
    parameter int unsigned PAYLOAD_MAX_SIZE = 1500,
    parameter int unsigned MIN_PAYLOAD_SIZE = 46,
    parameter logic [63:0] PREAMBLE_SFD     = 64'h55555555555555D5
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [63:0] i_frame_in,
    output logic [47:0] o_dest_address,
    output logic [47:0] o_src_address,
    output logic [15:0] o_eth_type,
    output logic [63:0] o_data,
    output logic        o_data_valid,
    output logic [7:0]  o_data_keep,
    output logic        o_data_last,
    output logic [15:0] o_payload_count,
    output logic        o_done,
    output logic        o_frame_ok,
    output logic        o_err_preamble,
    output logic        o_err_truncated,
    output logic        o_err_runt,
    output logic        o_err_oversize,
    output logic        o_err_length
);

    localparam logic [15:0] MIN_CNT      = 16'(MIN_PAYLOAD_SIZE);
    localparam logic [15:0] MAX_CNT      = 16'(PAYLOAD_MAX_SIZE);
    localparam logic [15:0] LEN_TYPE_MAX = 16'd1500;

    typedef enum logic [2:0] {IDLE, DROP, HDR1, HDR2, PAYLOAD} state_t;

    state_t      state, state_nxt;
    logic [15:0] hold, hold_d;
    logic [47:0] dest_d, src_d;
    logic [15:0] eth_d, count_d;
    logic [63:0] data_d;
    logic [7:0]  keep_d;
    logic        dv_d, last_d, done_d, ok_d;
    logic        e_pre_d, e_trunc_d, e_runt_d, e_over_d, e_len_d;
    logic [16:0] count_sum;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_valid) state_nxt = (i_frame_in == PREAMBLE_SFD) ? HDR1 : DROP;
            DROP:    if (!i_valid) state_nxt = IDLE;
            HDR1:    state_nxt = i_valid ? HDR2 : IDLE;
            HDR2:    state_nxt = i_valid ? PAYLOAD : IDLE;
            PAYLOAD: if (!i_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of every registered output; fields not touched hold their value.
    always_comb begin
        dest_d    = o_dest_address;
        src_d     = o_src_address;
        eth_d     = o_eth_type;
        hold_d    = hold;
        count_d   = o_payload_count;
        data_d    = o_data;
        keep_d    = '0;
        dv_d      = 1'b0;
        last_d    = 1'b0;
        done_d    = 1'b0;
        ok_d      = 1'b0;
        e_pre_d   = o_err_preamble;
        e_trunc_d = o_err_truncated;
        e_runt_d  = o_err_runt;
        e_over_d  = o_err_oversize;
        e_len_d   = o_err_length;
        count_sum = {1'b0, o_payload_count} + 17'd8;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    count_d   = '0;
                    e_pre_d   = 1'b0;
                    e_trunc_d = 1'b0;
                    e_runt_d  = 1'b0;
                    e_over_d  = 1'b0;
                    e_len_d   = 1'b0;
                end
            end
            DROP: begin
                if (!i_valid) begin
                    done_d  = 1'b1;
                    e_pre_d = 1'b1;
                end
            end
            HDR1: begin
                if (i_valid) begin
                    dest_d         = i_frame_in[63:16];
                    src_d[47:32]   = i_frame_in[15:0];
                end else begin
                    done_d    = 1'b1;
                    e_trunc_d = 1'b1;
                end
            end
            HDR2: begin
                if (i_valid) begin
                    src_d[31:0] = i_frame_in[63:32];
                    eth_d       = i_frame_in[31:16];
                    hold_d      = i_frame_in[15:0];
                    count_d     = 16'd2;
                end else begin
                    done_d    = 1'b1;
                    e_trunc_d = 1'b1;
                end
            end
            PAYLOAD: begin
                dv_d = 1'b1;
                if (i_valid) begin
                    data_d  = {hold, i_frame_in[63:16]};
                    keep_d  = 8'hFF;
                    hold_d  = i_frame_in[15:0];
                    count_d = count_sum[16] ? '1 : count_sum[15:0];
                end else begin
                    data_d   = {hold, 48'b0};
                    keep_d   = 8'hC0;
                    last_d   = 1'b1;
                    done_d   = 1'b1;
                    e_runt_d = (o_payload_count < MIN_CNT);
                    e_over_d = (o_payload_count > MAX_CNT);
                    e_len_d  = (o_eth_type <= LEN_TYPE_MAX) && (o_eth_type > o_payload_count);
                    ok_d     = !(e_runt_d || e_over_d || e_len_d);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            hold            <= '0;
            o_dest_address  <= '0;
            o_src_address   <= '0;
            o_eth_type      <= '0;
            o_payload_count <= '0;
            o_data          <= '0;
            o_data_keep     <= '0;
            o_data_valid    <= 1'b0;
            o_data_last     <= 1'b0;
            o_done          <= 1'b0;
            o_frame_ok      <= 1'b0;
            o_err_preamble  <= 1'b0;
            o_err_truncated <= 1'b0;
            o_err_runt      <= 1'b0;
            o_err_oversize  <= 1'b0;
            o_err_length    <= 1'b0;
        end else begin
            hold            <= hold_d;
            o_dest_address  <= dest_d;
            o_src_address   <= src_d;
            o_eth_type      <= eth_d;
            o_payload_count <= count_d;
            o_data          <= data_d;
            o_data_keep     <= keep_d;
            o_data_valid    <= dv_d;
            o_data_last     <= last_d;
            o_done          <= done_d;
            o_frame_ok      <= ok_d;
            o_err_preamble  <= e_pre_d;
            o_err_truncated <= e_trunc_d;
            o_err_runt      <= e_runt_d;
            o_err_oversize  <= e_over_d;
            o_err_length    <= e_len_d;
        end
    end

endmodule

// File: tb/tb_mac_frame_checker.sv
// Directed bench for mac_frame_checker: nominal, preamble, truncation,
// runt/oversize, length, back-to-back and mid-frame reset cases.
module tb_mac_frame_checker;

    localparam logic [63:0] PRE     = 64'h55555555555555D5;
    localparam logic [47:0] DST     = 48'h001122334455;
    localparam logic [47:0] SRC     = 48'h66778899AABB;

    logic        clk = 1'b0;
    logic        i_rst, i_valid;
    logic [63:0] i_frame_in;
    logic [47:0] o_dest_address, o_src_address;
    logic [15:0] o_eth_type, o_payload_count;
    logic [63:0] o_data;
    logic        o_data_valid, o_data_last, o_done, o_frame_ok;
    logic [7:0]  o_data_keep;
    logic        o_err_preamble, o_err_truncated, o_err_runt, o_err_oversize, o_err_length;

    mac_frame_checker #(
        .PAYLOAD_MAX_SIZE(1500),
        .MIN_PAYLOAD_SIZE(46),
        .PREAMBLE_SFD(PRE)
    ) dut (
        .clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_frame_in(i_frame_in),
        .o_dest_address(o_dest_address), .o_src_address(o_src_address),
        .o_eth_type(o_eth_type), .o_data(o_data), .o_data_valid(o_data_valid),
        .o_data_keep(o_data_keep), .o_data_last(o_data_last),
        .o_payload_count(o_payload_count), .o_done(o_done), .o_frame_ok(o_frame_ok),
        .o_err_preamble(o_err_preamble), .o_err_truncated(o_err_truncated),
        .o_err_runt(o_err_runt), .o_err_oversize(o_err_oversize),
        .o_err_length(o_err_length)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: record every beat and the status presented with each done pulse.
    logic [63:0] beat_data[$];
    logic [7:0]  beat_keep[$];
    logic        beat_last[$];
    int unsigned done_cnt = 0, ok_cnt = 0;
    logic [15:0] st_count = '0;
    logic [4:0]  st_err = '0;
    logic        st_ok = 1'b0;

    always @(negedge clk) begin
        if (!i_rst) begin
            if (o_data_valid) begin
                beat_data.push_back(o_data);
                beat_keep.push_back(o_data_keep);
                beat_last.push_back(o_data_last);
            end
            if (o_done) begin
                done_cnt <= done_cnt + 1;
                if (o_frame_ok) ok_cnt <= ok_cnt + 1;
                st_count <= o_payload_count;
                st_err   <= {o_err_preamble, o_err_truncated, o_err_runt, o_err_oversize, o_err_length};
                st_ok    <= o_frame_ok;
            end
        end
    end

    logic [7:0]  pay [0:2047];
    int unsigned b0, d0, o0;

    task automatic drive(input logic v, input logic [63:0] w);
        @(posedge clk);
        #1;
        i_valid    = v;
        i_frame_in = w;
    endtask

    function automatic logic [63:0] fword(input int unsigned k, input logic [15:0] eth);
        logic [63:0] w;
        w = '0;
        if (k == 1)      w = {DST, SRC[47:32]};
        else if (k == 2) w = {SRC[31:0], eth, pay[0], pay[1]};
        else
            for (int unsigned b = 0; b < 8; b++)
                w[63-8*b -: 8] = pay[2 + 8*(k-3) + b];
        return w;
    endfunction

    task automatic send_frame(input logic [63:0] pre, input logic [15:0] eth, input int unsigned nw);
        drive(1'b1, pre);
        for (int unsigned k = 1; k <= nw; k++) drive(1'b1, fword(k, eth));
        drive(1'b0, '0);
    endtask

    task automatic snap();
        b0 = beat_data.size();
        d0 = done_cnt;
        o0 = ok_cnt;
    endtask

    task automatic expect_status(input string tag, input int unsigned ndone, input int unsigned nbeats,
                                 input logic [15:0] cnt, input logic [4:0] err, input logic ok);
        repeat (3) drive(1'b0, '0);
        check({tag, ".done"},  64'(done_cnt - d0), 64'(ndone));
        check({tag, ".beats"}, 64'(beat_data.size() - b0), 64'(nbeats));
        check({tag, ".count"}, 64'(st_count), 64'(cnt));
        check({tag, ".err"},   64'(st_err), 64'(err));
        check({tag, ".ok"},    64'(st_ok), 64'(ok));
    endtask

    task automatic fill_nominal();
        for (int unsigned i = 0; i < 2048; i++) pay[i] = (i < 46) ? 8'h55 : 8'h00;
    endtask

    logic [63:0] exp_w;

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_frame_in = '0;
        fill_nominal();
        repeat (3) @(negedge clk);
        check("reset.outs", 64'(|{o_dest_address, o_src_address, o_eth_type, o_data, o_data_valid,
              o_data_keep, o_data_last, o_payload_count, o_done, o_frame_ok, o_err_preamble,
              o_err_truncated, o_err_runt, o_err_oversize, o_err_length}), 64'd0);
        @(posedge clk); #1; i_rst = 1'b0;
        drive(1'b0, '0);

        // Nominal: 50 payload bytes, seven beats
        snap();
        send_frame(PRE, 16'h0800, 8);
        expect_status("nom", 1, 7, 16'd50, 5'b00000, 1'b1);
        check("nom.dest", 64'(o_dest_address), 64'(DST));
        check("nom.src",  64'(o_src_address),  64'(SRC));
        check("nom.eth",  64'(o_eth_type),     64'h0800);
        for (int unsigned i = 0; i < 7; i++) begin
            for (int unsigned b = 0; b < 8; b++)
                exp_w[63-8*b -: 8] = (8*i + b < 50) ? pay[8*i + b] : 8'h00;
            check($sformatf("nom.data%0d", i), beat_data[b0+i], exp_w);
            check($sformatf("nom.keep%0d", i), 64'(beat_keep[b0+i]), (i < 6) ? 64'hFF : 64'hC0);
            check($sformatf("nom.last%0d", i), 64'(beat_last[b0+i]), 64'(i == 6));
        end

        // Bad preamble
        snap();
        send_frame(64'h5555555555555555, 16'h0800, 8);
        expect_status("badpre", 1, 0, 16'd0, 5'b10000, 1'b0);

        // Truncation in HDR1 and HDR2, then a 2-byte runt
        snap();
        send_frame(PRE, 16'h0800, 0);
        expect_status("trunc0", 1, 0, 16'd0, 5'b01000, 1'b0);
        snap();
        send_frame(PRE, 16'h0800, 1);
        expect_status("trunc1", 1, 0, 16'd0, 5'b01000, 1'b0);
        snap();
        send_frame(PRE, 16'h0800, 2);
        expect_status("hdr2only", 1, 1, 16'd2, 5'b00100, 1'b0);

        // Runt and oversize
        snap();
        send_frame(PRE, 16'h0800, 6);
        expect_status("runt", 1, 5, 16'd34, 5'b00100, 1'b0);
        for (int unsigned i = 0; i < 2048; i++) pay[i] = 8'(i);
        snap();
        send_frame(PRE, 16'h0800, 192);
        expect_status("over", 1, 191, 16'd1522, 5'b00010, 1'b0);
        fill_nominal();

        // Length field
        snap();
        send_frame(PRE, 16'd60, 8);
        expect_status("len60", 1, 7, 16'd50, 5'b00001, 1'b0);
        snap();
        send_frame(PRE, 16'd46, 8);
        expect_status("len46", 1, 7, 16'd50, 5'b00000, 1'b1);

        // Back-to-back with a single gap cycle
        snap();
        send_frame(PRE, 16'h0800, 8);
        send_frame(PRE, 16'h0800, 8);
        expect_status("b2b", 2, 14, 16'd50, 5'b00000, 1'b1);
        check("b2b.okcnt", 64'(ok_cnt - o0), 64'd2);

        // Reset asserted at header word 2, released mid-frame
        snap();
        drive(1'b1, PRE);
        drive(1'b1, fword(1, 16'h0800));
        @(posedge clk); #1;
        i_rst = 1'b1; i_valid = 1'b1; i_frame_in = fword(2, 16'h0800);
        @(negedge clk);
        check("midrst.outs", 64'(|{o_dest_address, o_src_address, o_eth_type, o_data, o_data_valid,
              o_data_keep, o_payload_count, o_done, o_err_preamble}), 64'd0);
        drive(1'b1, fword(3, 16'h0800));
        @(posedge clk); #1;
        i_rst = 1'b0; i_frame_in = fword(4, 16'h0800);
        for (int unsigned k = 5; k <= 8; k++) drive(1'b1, fword(k, 16'h0800));
        drive(1'b0, '0);
        expect_status("midrst", 1, 0, 16'd0, 5'b10000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
